id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk sampled on rising edge, rst synchronous active-high.
REQ-002 The port clk SHALL be: clk, input, 1, pipeline clock.
REQ-003 The port rst SHALL be: rst, input, 1, synchronous active-high reset.
REQ-004 The port if_valid SHALL be: if_valid, input, 1, fetch presents an instruction.
REQ-005 The port if_instr SHALL be: if_instr, input, 32, fetched instruction.
REQ-006 The port if_pc SHALL be: if_pc, input, 32, PC of the fetched instruction.
REQ-007 The port if_ready SHALL be: if_ready, output, 1, IF/ID register accepts this cycle.
REQ-008 The port ex_ready SHALL be: ex_ready, input, 1, EX stage accepts this cycle.
REQ-009 The port redirect SHALL be: redirect, input, 1, taken branch or jump resolved in EX, flush ID.
REQ-010 The port id_valid SHALL be: id_valid, output, 1, issued instruction valid; 0 means bubble.
REQ-011 The port id_instr SHALL be: id_instr, output, 32, held instruction, fed to the immediate generator and decoder.
REQ-012 The port id_pc SHALL be: id_pc, output, 32, held PC.
REQ-013 The port hazard_stall SHALL be: hazard_stall, output, 1, a load-use bubble is being inserted this cycle.
REQ-014 The port stall_cnt SHALL be: stall_cnt, output, 16, saturating count of load-use bubbles.

Function
REQ-015 The block SHALL hold one IF/ID entry, id_valid_q plus instr and pc, with states EMPTY (id_valid_q=0), FULL (id_valid_q=1, no hazard) and STALL (id_valid_q=1, hazard).
REQ-016 The block SHALL decode source use from opcode = instr[6:0]:
  - rs1 (instr[19:15]) is used for opcodes 0010011, 0000011, 0100011, 1100011, 1100111 and 0110011.
  - rs2 (instr[24:20]) is used for opcodes 0100011, 1100011 and 0110011.
  - LUI, AUIPC, JAL and all other opcodes use no source register.
REQ-017 The block SHALL keep load_pending and load_rd[4:0], describing the most recently issued instruction.
REQ-018 hazard SHALL equal id_valid_q & load_pending & (load_rd != 0) & (used rs1 == load_rd | used rs2 == load_rd).
REQ-019 issue SHALL equal id_valid_q & ex_ready & ~hazard & ~redirect; the outputs SHALL be id_valid = id_valid_q & ~hazard & ~redirect, and hazard_stall = hazard & ~redirect.
REQ-020 if_ready SHALL equal ~redirect & (~id_valid_q | issue).
REQ-021 When if_valid & if_ready, the block SHALL capture if_instr/if_pc into the entry and set id_valid_q=1.
  - Otherwise, on issue, id_valid_q SHALL become 0.
  - Otherwise, the entry SHALL hold unchanged.
REQ-022 load_pending update:
  - On issue: load_pending <= (opcode==0000011) & (rd != 0), and load_rd <= instr[11:7].
  - On a non-issue cycle with ex_ready=1: load_pending <= 0.
  - Otherwise: load_pending holds.
  - Result: exactly one bubble per load-use pair when ex_ready=1.
REQ-023 On redirect=1, with priority over all except rst, the block SHALL on the next edge:
  - clear id_valid_q and load_pending;
  - drop the fetch offered that cycle;
  - leave stall_cnt unchanged.
REQ-024 A load writing x0 SHALL never cause a hazard.
REQ-025 A hazard with ex_ready=0 SHALL keep the entry, and stall_cnt SHALL still count that cycle.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with hazard_stall=1, and SHALL saturate at 0xFFFF without wrapping.
REQ-027 Latency: an instruction captured at edge N SHALL appear on id_* in cycle N+1 and SHALL issue at edge N+1 when no hazard, redirect or backpressure applies; back-to-back throughput SHALL be 1 per cycle.

Reset
REQ-028 While rst=1 at an edge, the block SHALL clear id_valid_q, load_pending, load_rd, id_instr, id_pc and stall_cnt to 0, and SHALL set id_valid=0, hazard_stall=0 and if_ready=1 (if_ready=1 unless redirect=1).
REQ-029 rst asserted mid-stall SHALL discard the held entry; after reset the block SHALL be in EMPTY.

Verification
REQ-030 Load-use: issue lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) with ex_ready=1 -> one cycle with id_valid=0, hazard_stall=1, if_ready=0; add issues next cycle; stall_cnt=1.
REQ-031 No-use and x0: lw x5 then lui x5,1 (0x000012B7) -> no bubble; lw x0,0(x1) (0x0000A003) then an instruction reading x0 -> no bubble; stall_cnt unchanged.
REQ-032 Backpressure: ex_ready=0 for 3 cycles while FULL without hazard -> id_instr and id_pc stable, if_ready=0, then issue when ex_ready=1.
REQ-033 Redirect during stall: redirect=1 while STALL with if_valid=1 -> if_ready=0; next cycle id_valid=0, load_pending=0, offered fetch not captured.
REQ-034 Saturation: preload 65535 hazard cycles, then one more -> stall_cnt stays 0xFFFF.
REQ-035 Reset mid-operation: rst=1 for 1 cycle while FULL with stall_cnt=7 -> id_valid=0, stall_cnt=0, if_ready=1 next cycle.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
// Fetch/decode/execute handshake bundle for the ID-stage hazard controller.
// slave is the controller side, master is the surrounding pipeline.
interface id_hazard_ctrl_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        redirect;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        hazard_stall;
  logic [15:0] stall_cnt;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, redirect,
    output if_ready, id_valid, id_instr, id_pc, hazard_stall, stall_cnt
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, redirect,
    input  if_ready, id_valid, id_instr, id_pc, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// IF/ID pipeline register with load-use interlock, redirect flush and a
// saturating bubble counter.
//
// state | meaning
// EMPTY | no instruction held
// FULL  | instruction held, free to issue
// STALL | instruction held, reads the rd of the load just issued
module id_hazard_ctrl (
  input  logic             clk,
  input  logic             rst,
  id_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        load_pending_q, load_pending_d;
  logic [4:0]  load_rd_q, load_rd_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic valid, valid_d, hazard, issue, capture, hazard_stall, if_ready;

  function automatic logic src_match(input logic [31:0] instr, input logic [4:0] rd);
    logic [6:0] op;
    logic       use_rs1;
    logic       use_rs2;
    op      = instr[6:0];
    use_rs1 = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b0100011) ||
              (op == 7'b1100011) || (op == 7'b1100111) || (op == 7'b0110011);
    use_rs2 = (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b0110011);
    return (use_rs1 && (instr[19:15] == rd)) || (use_rs2 && (instr[24:20] == rd));
  endfunction

  always_comb begin
    valid          = (state_q != EMPTY);
    hazard         = (state_q == STALL);
    issue          = valid & bus.ex_ready & ~hazard & ~bus.redirect;
    if_ready       = ~bus.redirect & (~valid | issue);
    capture        = bus.if_valid & if_ready;
    hazard_stall   = hazard & ~bus.redirect;

    valid_d        = valid;
    instr_d        = instr_q;
    pc_d           = pc_q;
    load_pending_d = load_pending_q;
    load_rd_d      = load_rd_q;
    stall_cnt_d    = stall_cnt_q;

    // capture is already blocked by redirect through if_ready
    if (capture) begin
      valid_d = 1'b1;
      instr_d = bus.if_instr;
      pc_d    = bus.if_pc;
    end else if (issue || bus.redirect) begin
      valid_d = 1'b0;
    end

    if (bus.redirect) begin
      load_pending_d = 1'b0;
    end else if (issue) begin
      load_pending_d = (instr_q[6:0] == 7'b0000011) && (instr_q[11:7] != 5'd0);
      load_rd_d      = instr_q[11:7];
    end else if (bus.ex_ready) begin
      load_pending_d = 1'b0;
    end

    if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // hazard is resolved a cycle early so STALL is a plain registered state
    if (!valid_d) begin
      state_d = EMPTY;
    end else if (load_pending_d && (load_rd_d != 5'd0) && src_match(instr_d, load_rd_d)) begin
      state_d = STALL;
    end else begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      instr_q        <= 32'd0;
      pc_q           <= 32'd0;
      load_pending_q <= 1'b0;
      load_rd_q      <= 5'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      pc_q           <= pc_d;
      load_pending_q <= load_pending_d;
      load_rd_q      <= load_rd_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign bus.if_ready     = if_ready;
  assign bus.id_valid     = valid & ~hazard & ~bus.redirect;
  assign bus.id_instr     = instr_q;
  assign bus.id_pc        = pc_q;
  assign bus.hazard_stall = hazard_stall;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Vector-table bench for id_hazard_ctrl: each record holds one cycle of inputs
// plus the outputs expected during that cycle, before the next rising edge.
module tb_id_hazard_ctrl;

  localparam logic [31:0] LW5  = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADD  = 32'h00728333;  // add  x6,x5,x7
  localparam logic [31:0] NOP  = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] LUIX = 32'h00028337;  // lui  x6 with bits[19:15]=5
  localparam logic [31:0] LUI5 = 32'h000012B7;  // lui  x5,1
  localparam logic [31:0] LW0  = 32'h0000A003;  // lw   x0,0(x1)
  localparam logic [31:0] ADD0 = 32'h00700333;  // add  x6,x0,x7
  localparam logic [31:0] SW5  = 32'h0050A023;  // sw   x5,0(x1)

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        er;
    logic        redir;
    logic        x_ir;
    logic        x_idv;
    logic        x_hs;
    logic [31:0] x_instr;
    logic [31:0] x_pc;
    logic [15:0] x_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  id_hazard_ctrl_if bus ();

  id_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic iv, logic [31:0] ins, logic [31:0] pc,
                              logic er, logic rd, logic ir, logic idv, logic hs,
                              logic [31:0] xi, logic [31:0] xp, logic [15:0] xc);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.instr = ins;  v.pc = pc;  v.er = er;  v.redir = rd;
    v.x_ir = ir;  v.x_idv = idv;  v.x_hs = hs;  v.x_instr = xi;  v.x_pc = xp;  v.x_cnt = xc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst          = v.rst;
    bus.if_valid = v.iv;
    bus.if_instr = v.instr;
    bus.if_pc    = v.pc;
    bus.ex_ready = v.er;
    bus.redirect = v.redir;
  endtask

  task automatic apply(input string name, input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    n_vec++;
    if (bus.if_ready !== e.x_ir) begin
      n_err++;
      $display("FAIL %s if_ready got %0b want %0b", name, bus.if_ready, e.x_ir);
    end
    if (bus.id_valid !== e.x_idv) begin
      n_err++;
      $display("FAIL %s id_valid got %0b want %0b", name, bus.id_valid, e.x_idv);
    end
    if (bus.hazard_stall !== e.x_hs) begin
      n_err++;
      $display("FAIL %s hazard_stall got %0b want %0b", name, bus.hazard_stall, e.x_hs);
    end
    if (bus.id_instr !== e.x_instr) begin
      n_err++;
      $display("FAIL %s id_instr got %h want %h", name, bus.id_instr, e.x_instr);
    end
    if (bus.id_pc !== e.x_pc) begin
      n_err++;
      $display("FAIL %s id_pc got %h want %h", name, bus.id_pc, e.x_pc);
    end
    if (bus.stall_cnt !== e.x_cnt) begin
      n_err++;
      $display("FAIL %s stall_cnt got %h want %h", name, bus.stall_cnt, e.x_cnt);
    end
  endtask

  initial begin
    // reset, load-use, no-use, x0 load, store rs2 hazard
    tbl.push_back(mk(1,0,0,0,1,0,       1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,LW5,'h100,1,0, 1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,ADD,'h104,1,0, 1,1,0, LW5,'h100,0));
    tbl.push_back(mk(0,1,NOP,'h108,1,0, 0,0,1, ADD,'h104,0));
    tbl.push_back(mk(0,1,NOP,'h108,1,0, 1,1,0, ADD,'h104,1));
    tbl.push_back(mk(0,1,LW5,'h10C,1,0, 1,1,0, NOP,'h108,1));
    tbl.push_back(mk(0,1,LUIX,'h110,1,0,1,1,0, LW5,'h10C,1));
    tbl.push_back(mk(0,1,LW5,'h114,1,0, 1,1,0, LUIX,'h110,1));
    tbl.push_back(mk(0,1,LUI5,'h118,1,0,1,1,0, LW5,'h114,1));
    tbl.push_back(mk(0,1,LW0,'h11C,1,0, 1,1,0, LUI5,'h118,1));
    tbl.push_back(mk(0,1,ADD0,'h120,1,0,1,1,0, LW0,'h11C,1));
    tbl.push_back(mk(0,1,LW5,'h124,1,0, 1,1,0, ADD0,'h120,1));
    tbl.push_back(mk(0,1,SW5,'h128,1,0, 1,1,0, LW5,'h124,1));
    tbl.push_back(mk(0,1,NOP,'h12C,1,0, 0,0,1, SW5,'h128,1));
    tbl.push_back(mk(0,1,NOP,'h12C,1,0, 1,1,0, SW5,'h128,2));
    // backpressure while FULL
    tbl.push_back(mk(0,1,ADD,'h130,0,0, 0,1,0, NOP,'h12C,2));
    tbl.push_back(mk(0,1,ADD,'h130,0,0, 0,1,0, NOP,'h12C,2));
    tbl.push_back(mk(0,1,ADD,'h130,0,0, 0,1,0, NOP,'h12C,2));
    tbl.push_back(mk(0,1,ADD,'h130,1,0, 1,1,0, NOP,'h12C,2));
    tbl.push_back(mk(0,0,0,0,1,0,       1,1,0, ADD,'h130,2));
    // hazard under backpressure, then redirect while stalled
    tbl.push_back(mk(0,1,LW5,'h200,1,0, 1,0,0, ADD,'h130,2));
    tbl.push_back(mk(0,1,ADD,'h204,1,0, 1,1,0, LW5,'h200,2));
    tbl.push_back(mk(0,1,NOP,'h208,0,0, 0,0,1, ADD,'h204,2));
    tbl.push_back(mk(0,1,NOP,'h208,0,0, 0,0,1, ADD,'h204,3));
    tbl.push_back(mk(0,1,NOP,'h208,0,1, 0,0,0, ADD,'h204,4));
    tbl.push_back(mk(0,1,SW5,'h20C,0,0, 1,0,0, ADD,'h204,4));
    tbl.push_back(mk(0,0,0,0,1,0,       1,1,0, SW5,'h20C,4));
    tbl.push_back(mk(0,0,0,0,1,0,       1,0,0, SW5,'h20C,4));

    drive(mk(1,0,0,0,1,0, 0,0,0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // reset while FULL with stall_cnt=7
    apply("rst_a", mk(0,1,LW5,'h300,1,0, 1,0,0, SW5,'h20C,4));
    apply("rst_b", mk(0,1,ADD,'h304,1,0, 1,1,0, LW5,'h300,4));
    apply("rst_c", mk(0,0,0,0,0,0,       0,0,1, ADD,'h304,4));
    apply("rst_d", mk(0,0,0,0,0,0,       0,0,1, ADD,'h304,5));
    apply("rst_e", mk(0,0,0,0,1,0,       0,0,1, ADD,'h304,6));
    apply("rst_f", mk(0,0,0,0,0,0,       0,1,0, ADD,'h304,7));
    apply("rst_g", mk(1,1,NOP,'h308,0,0, 0,1,0, ADD,'h304,7));
    apply("rst_h", mk(0,0,0,0,1,0,       1,0,0, 0,0,0));

    // saturation: hold a load-use stall with ex_ready low
    drive(mk(0,1,LW5,'h400,1,0, 0,0,0,0,0,0));
    drive(mk(0,1,ADD,'h404,1,0, 0,0,0,0,0,0));
    for (int i = 0; i < 65534; i++) drive(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    apply("sat_a", mk(0,0,0,0,0,0, 0,0,1, ADD,'h404,16'hFFFE));
    apply("sat_b", mk(0,0,0,0,0,0, 0,0,1, ADD,'h404,16'hFFFF));
    apply("sat_c", mk(0,0,0,0,1,0, 0,0,1, ADD,'h404,16'hFFFF));
    apply("sat_d", mk(0,0,0,0,1,0, 1,1,0, ADD,'h404,16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
